// File: rtl/multicycle_ctrl_unit.sv
// Multicycle RV32I control unit: Moore sequencing FSM with memory-ready stalls,
// plus the combinational ALU decoder and immediate-format select.
module multicycle_ctrl_unit #(
  parameter bit SUPPORT_BNE = 1'b1,
  parameter bit SUPPORT_XOR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode_s,
  input  logic [2:0] f3_s,
  input  logic       f7_5_s,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcWrite_s,
  output logic       adrSrc_s,
  output logic       memWrite_s,
  output logic       irWrite_s,
  output logic [1:0] resultSrc_s,
  output logic [1:0] aluSrcA_s,
  output logic [1:0] aluSrcB_s,
  output logic       regWrite_s,
  output logic [1:0] inmSrc_s,
  output logic [2:0] aluCtrl_s,
  output logic [3:0] state_s
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       branch, pc_update, take;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_s)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BR:             state_d = S_BRANCH;
          default:           state_d = S_FETCH;
        endcase
      end
      // opcode bit 5 separates store (0100011) from load (0000011)
      S_MEMADR:   state_d = opcode_s[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Moore decode of the current state; irWrite/pcUpdate in FETCH gate on mem_ready
  always_comb begin
    adrSrc_s    = 1'b0;
    memWrite_s  = 1'b0;
    irWrite_s   = 1'b0;
    resultSrc_s = 2'b00;
    aluSrcA_s   = 2'b00;
    aluSrcB_s   = 2'b00;
    regWrite_s  = 1'b0;
    alu_op      = 2'b00;
    branch      = 1'b0;
    pc_update   = 1'b0;
    case (state_q)
      S_FETCH: begin
        irWrite_s   = mem_ready;
        aluSrcB_s   = 2'b10;
        resultSrc_s = 2'b10;
        pc_update   = mem_ready;
      end
      S_DECODE: begin
        aluSrcA_s = 2'b01;
        aluSrcB_s = 2'b01;
      end
      S_MEMADR: begin
        aluSrcA_s = 2'b10;
        aluSrcB_s = 2'b01;
      end
      S_MEMREAD:  adrSrc_s = 1'b1;
      S_MEMWB: begin
        resultSrc_s = 2'b01;
        regWrite_s  = 1'b1;
      end
      S_MEMWRITE: begin
        adrSrc_s   = 1'b1;
        memWrite_s = 1'b1;
      end
      S_EXECR: begin
        aluSrcA_s = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        aluSrcA_s = 2'b10;
        aluSrcB_s = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB:    regWrite_s = 1'b1;
      S_BRANCH: begin
        aluSrcA_s = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_JAL: begin
        aluSrcA_s = 2'b01;
        aluSrcB_s = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    take = 1'b0;
    if (f3_s == 3'b000)                     take = zero;
    else if (SUPPORT_BNE && f3_s == 3'b001) take = !zero;
  end

  assign pcWrite_s = pc_update | (branch & take);

  always_comb begin
    case (opcode_s)
      OP_STORE: inmSrc_s = 2'b01;
      OP_BR:    inmSrc_s = 2'b10;
      OP_JAL:   inmSrc_s = 2'b11;
      default:  inmSrc_s = 2'b00;
    endcase
  end

  always_comb begin
    aluCtrl_s = ALU_ADD;
    case (alu_op)
      2'b01: aluCtrl_s = ALU_SUB;
      2'b10: begin
        case (f3_s)
          3'b000:  aluCtrl_s = (opcode_s[5] & f7_5_s) ? ALU_SUB : ALU_ADD;
          3'b010:  aluCtrl_s = ALU_SLT;
          3'b110:  aluCtrl_s = ALU_OR;
          3'b111:  aluCtrl_s = ALU_AND;
          3'b100:  aluCtrl_s = SUPPORT_XOR ? ALU_XOR : ALU_ADD;
          default: aluCtrl_s = ALU_ADD;
        endcase
      end
      default: aluCtrl_s = ALU_ADD;
    endcase
  end

  assign state_s = state_q;

endmodule

// File: doc/multicycle_ctrl_unit.md
# multicycle_ctrl_unit

Multicycle RV32I control unit: Moore FSM plus combinational ALU decoder that sequences fetch, decode, execute, memory and writeback over several cycles through a shared memory port and one ALU. Sits beside the multicycle datapath and replaces the single-cycle control unit. Adds a memory-ready stall handshake and parameter-selected BNE and XOR support.

## Interface
- SUPPORT_BNE, 0, 1 = branch state also handles f3=001 (bne); 0 = only beq.
- SUPPORT_XOR, 0, 1 = ALU decoder maps f3=100 (R/I ALU) to aluCtrl 100; 0 = maps it to add.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode_s  in  7  opcode from instruction register.
- f3_s  in  3  funct3 from instruction register.
- f7_5_s  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes access this cycle; tie 1 for single-cycle memory.
- pcWrite_s  out  1  PC register enable.
- adrSrc_s  out  1  0 = address from PC, 1 = from ALUOut.
- memWrite_s  out  1  memory write strobe.
- irWrite_s  out  1  instruction register and oldPC enable.
- resultSrc_s  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- aluSrcA_s  out  2  00 PC, 01 oldPC, 10 rs1 register.
- aluSrcB_s  out  2  00 rs2 register, 01 immediate, 10 constant 4.
- regWrite_s  out  1  register file write enable.
- inmSrc_s  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- aluCtrl_s  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- state_s  out  4  current state, debug.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10. Codes 11–15 are unreachable and go to FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready, else stay.
  - DECODE: opcode 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1101111 → JAL; 1100011 → BRANCH; anything else → FETCH, with no write strobes issued.
  - MEMADR: load → MEMREAD; store → MEMWRITE.
  - MEMREAD→MEMWB when mem_ready, else stay.
  - MEMWB → FETCH.
  - MEMWRITE→FETCH when mem_ready, else stay with memWrite held.
  - EXECR, EXECI, JAL → ALUWB.
  - ALUWB → FETCH.
  - BRANCH → FETCH.
- Moore outputs; any signal not listed for a state is 0.
  - FETCH: adrSrc 0, irWrite = mem_ready, aluSrcA 00, aluSrcB 10, aluOp 00, resultSrc 10, pcUpdate = mem_ready.
  - DECODE: aluSrcA 01, aluSrcB 01, aluOp 00.
  - MEMADR: aluSrcA 10, aluSrcB 01, aluOp 00.
  - MEMREAD: adrSrc 1, resultSrc 00.
  - MEMWB: resultSrc 01, regWrite 1.
  - MEMWRITE: adrSrc 1, resultSrc 00, memWrite 1.
  - EXECR: aluSrcA 10, aluSrcB 00, aluOp 10.
  - EXECI: aluSrcA 10, aluSrcB 01, aluOp 10.
  - ALUWB: resultSrc 00, regWrite 1.
  - BRANCH: aluSrcA 10, aluSrcB 00, aluOp 01, resultSrc 00, branch 1.
  - JAL: aluSrcA 01, aluSrcB 10, aluOp 00, resultSrc 00, pcUpdate 1.
- pcWrite = pcUpdate | (branch & take).
  - take = zero when f3=000.
  - take = !zero when SUPPORT_BNE=1 and f3=001.
  - otherwise take = 0.
- inmSrc, from opcode only: load/I-ALU 00, store 01, branch 10, jal 11, others 00.
- ALU decoder:
  - aluOp 00 → add; aluOp 01 → sub.
  - aluOp 10, by f3:
    - 000: sub if opcode[5]&f7_5, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - 100: xor if SUPPORT_XOR, else add.
    - others: add.

## Timing
- rst_n low → state FETCH immediately (asynchronous). While in reset, outputs are the FETCH decode, but the state register cannot advance.
- Reset deasserted mid-instruction: restart at FETCH; no partial writeback occurs after reset.
- Cycles per instruction with mem_ready=1: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq/bne 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle; irWrite/pcWrite stay 0 during FETCH stall.
- regWrite and memWrite are each high for exactly one cycle per instruction, except memWrite held through MEMWRITE stall.
- pcWrite in BRANCH is combinational on zero in the same cycle.

## Test plan
- Reset then mem_ready=1, IR=lw (0000011): state 0,1,2,3,4,0; regWrite=1 only in state 4, resultSrc=01; irWrite=1 in cycle 0.
- sw with mem_ready low 2 cycles in MEMWRITE: memWrite=1 for 3 cycles, adrSrc=1, then FETCH; regWrite never 1.
- R-type sub (f3=000, f7_5=1, opcode 0110011): EXECR aluCtrl=001; add variant (f7_5=0) → 000; f3=111 → 010; f3=100 → 100 with SUPPORT_XOR=1, 000 with SUPPORT_XOR=0.
- beq zero=1 → pcWrite=1 in BRANCH; zero=0 → 0. SUPPORT_BNE=1, f3=001, zero=0 → pcWrite=1. SUPPORT_BNE=0, same stimulus → 0.
- FETCH with mem_ready=0 for 3 cycles: state stays 0, irWrite=pcWrite=0; fourth cycle mem_ready=1 → both 1, next state 1.
- Illegal opcode 1111111: DECODE→FETCH, no regWrite/memWrite. rst_n pulsed low in state 3 → state_s=0 asynchronously.
